// File: rtl/adc_spi_responder.sv
// SPI mode-0 responder standing in for the thermocouple ADC: shifts a held conversion word
// MSB-first on adc_sin after LEAD_BITS zeros and captures the master's first 8 bits as a command.
module adc_spi_responder #(
    parameter int unsigned DATA_BITS   = 12,
    parameter int unsigned LEAD_BITS   = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adc_sck,
    input  logic                 adc_sce,
    input  logic                 adc_sout,
    output logic                 adc_sin,
    input  logic [DATA_BITS-1:0] sample_data,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic [7:0]           cmd,
    output logic                 cmd_valid,
    output logic                 frame_done,
    output logic                 frame_abort,
    output logic                 stale,
    output logic                 busy
);

    localparam int unsigned FRAME_W = LEAD_BITS + DATA_BITS;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned FLUSH_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sck_sync, sce_sync, sout_sync;
    logic                   sck_d, sce_d;
    logic                   sck_s, sce_s, sout_s;
    logic                   sck_rise, sck_fall, sce_rise, sce_fall;

    logic [DATA_BITS-1:0]   hold_reg;
    logic                   fresh;
    logic [FRAME_W-1:0]     shreg;
    logic [FRAME_W-1:0]     frame_word;
    logic [CNT_W-1:0]       bit_cnt;
    logic [7:0]             rx;
    logic [3:0]             rx_cnt;
    logic [FLUSH_W-1:0]     flush_cnt;

    logic frame_start, frame_end, shift_in, shift_out;

    assign sck_s      = sck_sync[SYNC_STAGES-1];
    assign sce_s      = sce_sync[SYNC_STAGES-1];
    assign sout_s     = sout_sync[SYNC_STAGES-1];
    assign sck_rise   = sck_s & ~sck_d;
    assign sck_fall   = ~sck_s & sck_d;
    assign sce_rise   = sce_s & ~sce_d;
    assign sce_fall   = ~sce_s & sce_d;
    assign frame_word = FRAME_W'(hold_reg);

    // Pin synchronizers plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= '0;
            sce_sync  <= '1;
            sout_sync <= '0;
            sck_d     <= 1'b0;
            sce_d     <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], adc_sck};
            sce_sync  <= {sce_sync[SYNC_STAGES-2:0], adc_sce};
            sout_sync <= {sout_sync[SYNC_STAGES-2:0], adc_sout};
            sck_d     <= sck_s;
            sce_d     <= sce_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_IDLE;
        else     state <= state_next;
    end

    // WAIT_IDLE trusts sce only once the reset values have flushed out of the synchronizer
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        shift_in    = 1'b0;
        shift_out   = 1'b0;
        case (state)
            WAIT_IDLE: begin
                if (flush_cnt == FLUSH_W'(SYNC_STAGES) && sce_s) state_next = IDLE;
            end
            IDLE: begin
                if (sce_fall) begin
                    state_next  = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (sce_rise) begin
                    state_next = IDLE;
                    frame_end  = 1'b1;
                end else begin
                    shift_in  = sck_rise;
                    shift_out = sck_fall;
                end
            end
            default: state_next = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adc_sin      <= 1'b0;
            sample_ready <= 1'b0;
            cmd          <= '0;
            cmd_valid    <= 1'b0;
            frame_done   <= 1'b0;
            frame_abort  <= 1'b0;
            stale        <= 1'b0;
            busy         <= 1'b0;
            hold_reg     <= '0;
            fresh        <= 1'b0;
            shreg        <= '0;
            bit_cnt      <= '0;
            rx           <= '0;
            rx_cnt       <= '0;
            flush_cnt    <= '0;
        end else begin
            sample_ready <= 1'b1;
            cmd_valid    <= 1'b0;
            frame_done   <= 1'b0;
            frame_abort  <= 1'b0;
            busy         <= (state_next == ACTIVE);

            if (state == WAIT_IDLE && flush_cnt != FLUSH_W'(SYNC_STAGES))
                flush_cnt <= flush_cnt + FLUSH_W'(1);

            if (frame_start) begin
                shreg   <= frame_word;
                adc_sin <= frame_word[FRAME_W-1];
                bit_cnt <= '0;
                rx      <= '0;
                rx_cnt  <= '0;
                stale   <= ~fresh;
                fresh   <= 1'b0;
            end

            // Only the first 8 received bits form the command
            if (shift_in && rx_cnt != 4'd8) begin
                rx     <= {rx[6:0], sout_s};
                rx_cnt <= rx_cnt + 4'd1;
            end

            if (shift_out) begin
                shreg   <= shreg << 1;
                adc_sin <= shreg[FRAME_W-2];
                if (bit_cnt != CNT_W'(FRAME_W)) bit_cnt <= bit_cnt + CNT_W'(1);
            end

            if (frame_end) begin
                adc_sin <= 1'b0;
                if (bit_cnt >= CNT_W'(FRAME_W)) frame_done  <= 1'b1;
                else                            frame_abort <= 1'b1;
                if (rx_cnt == 4'd8) begin
                    cmd       <= rx;
                    cmd_valid <= 1'b1;
                end
            end

            // A load coincident with frame start lands in the holding register only
            if (sample_valid) begin
                hold_reg <= sample_data;
                fresh    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: a behavioural SPI master runs a table of frames,
// then hand-written sequences cover reset during an active frame.
module tb_adc_spi_responder;

    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        adc_sck, adc_sce, adc_sout, adc_sin;
    logic [11:0] sample_data;
    logic        sample_valid, sample_ready;
    logic [7:0]  cmd;
    logic        cmd_valid, frame_done, frame_abort, stale, busy;

    int checks = 0;
    int errors = 0;
    int n_done, n_abort, n_cmdv;

    typedef struct {
        logic        load;
        logic [11:0] sample;
        logic        mid;
        logic [11:0] mid_val;
        logic [7:0]  tx;
        int          n;
        logic [31:0] exp_rx;
        int          exp_done;
        int          exp_abort;
        int          exp_cmdv;
        logic [7:0]  exp_cmd;
        logic        exp_stale;
    } vec_t;

    vec_t vecs[7];

    adc_spi_responder #(.DATA_BITS(12), .LEAD_BITS(3), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .adc_sck(adc_sck), .adc_sce(adc_sce), .adc_sout(adc_sout), .adc_sin(adc_sin),
        .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .cmd(cmd), .cmd_valid(cmd_valid), .frame_done(frame_done), .frame_abort(frame_abort),
        .stale(stale), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done)  n_done++;
        if (frame_abort) n_abort++;
        if (cmd_valid)   n_cmdv++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        n_done = 0; n_abort = 0; n_cmdv = 0;
    endtask

    task automatic load_sample(input logic [11:0] v);
        @(negedge clk);
        sample_data = v; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        logic [31:0] rxw;
        int          busy_err;
        rxw = 0; busy_err = 0;
        if (v.load) load_sample(v.sample);
        clear_counts();
        @(negedge clk); adc_sce = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < v.n; i++) begin
            adc_sout = (i < 8) ? v.tx[7-i] : 1'b0;
            repeat (H) @(negedge clk);
            adc_sck = 1'b1;
            rxw = {rxw[30:0], adc_sin};
            if (!busy) busy_err++;
            if (v.mid && i == 5) begin
                sample_data = v.mid_val; sample_valid = 1'b1;
                @(negedge clk);
                sample_valid = 1'b0;
                repeat (H-1) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            adc_sck = 1'b0;
        end
        repeat (H) @(negedge clk);
        adc_sce = 1'b1;
        repeat (H) @(negedge clk);
        check($sformatf("f%0d rx_bits", idx), rxw, v.exp_rx);
        check($sformatf("f%0d frame_done_cnt", idx), n_done, v.exp_done);
        check($sformatf("f%0d frame_abort_cnt", idx), n_abort, v.exp_abort);
        check($sformatf("f%0d cmd_valid_cnt", idx), n_cmdv, v.exp_cmdv);
        check($sformatf("f%0d cmd", idx), cmd, v.exp_cmd);
        check($sformatf("f%0d stale", idx), stale, v.exp_stale);
        check($sformatf("f%0d busy_low_during_frame", idx), busy_err, 0);
        check($sformatf("f%0d busy_after", idx), busy, 0);
    endtask

    initial begin
        vec_t rv;
        int   bad;
        //         load  sample   mid   mid_val  tx     n   exp_rx         dn ab cv exp_cmd stale
        vecs[0] = '{1'b1, 12'hA5C, 1'b0, 12'h000, 8'hC3, 15, 32'h0000_0A5C, 1, 0, 1, 8'hC3, 1'b0};
        vecs[1] = '{1'b0, 12'h000, 1'b0, 12'h000, 8'h5A, 15, 32'h0000_0A5C, 1, 0, 1, 8'h5A, 1'b1};
        vecs[2] = '{1'b0, 12'h000, 1'b1, 12'h123, 8'h00, 15, 32'h0000_0A5C, 1, 0, 1, 8'h00, 1'b1};
        vecs[3] = '{1'b0, 12'h000, 1'b0, 12'h000, 8'h81, 15, 32'h0000_0123, 1, 0, 1, 8'h81, 1'b0};
        vecs[4] = '{1'b1, 12'hFFF, 1'b0, 12'h000, 8'hFF,  6, 32'h0000_0007, 0, 1, 0, 8'h81, 1'b0};
        vecs[5] = '{1'b0, 12'h000, 1'b0, 12'h000, 8'h3C, 15, 32'h0000_0FFF, 1, 0, 1, 8'h3C, 1'b1};
        vecs[6] = '{1'b1, 12'h801, 1'b0, 12'h000, 8'h96, 18, 32'h0000_4008, 1, 0, 1, 8'h96, 1'b0};

        rst = 1'b1; adc_sck = 1'b0; adc_sce = 1'b1; adc_sout = 1'b0;
        sample_data = '0; sample_valid = 1'b0;
        clear_counts();
        repeat (3) @(negedge clk);
        check("reset adc_sin", adc_sin, 0);
        check("reset sample_ready", sample_ready, 0);
        check("reset busy", busy, 0);
        check("reset stale", stale, 0);
        check("reset cmd", cmd, 0);
        check("reset pulses", frame_done | frame_abort | cmd_valid, 0);
        rst = 1'b0;
        repeat (H) @(negedge clk);
        check("sample_ready after reset", sample_ready, 1);

        for (int i = 0; i < 7; i++) run_frame(vecs[i], i);

        // Reset mid-frame with CE held low: responder must stay silent until CE returns high
        load_sample(12'h777);
        clear_counts();
        @(negedge clk); adc_sce = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            repeat (H) @(negedge clk); adc_sck = 1'b1;
            repeat (H) @(negedge clk); adc_sck = 1'b0;
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("rst mid adc_sin", adc_sin, 0);
        check("rst mid busy", busy, 0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            adc_sout = 1'b1;
            repeat (H) @(negedge clk); adc_sck = 1'b1;
            if (adc_sin !== 1'b0 || busy !== 1'b0) bad++;
            repeat (H) @(negedge clk); adc_sck = 1'b0;
        end
        check("rst mid silent while CE low", bad, 0);
        repeat (H) @(negedge clk);
        adc_sce = 1'b1;
        repeat (2*H) @(negedge clk);
        check("rst mid no pulses", n_done + n_abort + n_cmdv, 0);
        check("rst mid stale cleared", stale, 0);

        rv = '{1'b0, 12'h000, 1'b0, 12'h000, 8'h11, 15, 32'h0000_0000, 1, 0, 1, 8'h11, 1'b1};
        run_frame(rv, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- Synthesizable SPI slave that acts as the far end of the thermocouple design's ADC SPI master.
- Presents a conversion word, supplied by a local sample source, MSB-first on adc_sin.
- Captures the master's command byte from adc_sout.
- Used as an on-chip ADC stand-in for self-test and as the ADC model in the system bench. SPI mode 0; fully oversampled by clk.

Parameters:
DATA_BITS, 12, width of conversion word
LEAD_BITS, 3, zero bits sent before the MSB (sample/null period), 0..7
SYNC_STAGES, 2, synchronizer flops on adc_sck/adc_sce/adc_sout, >=2

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
adc_sck  in  1  SPI clock from master, idle low
adc_sce  in  1  chip enable from master, active-low
adc_sout  in  1  master-out data
adc_sin  out  1  responder-out data to master
sample_data  in  DATA_BITS  next conversion value
sample_valid  in  1  sample_data valid this cycle
sample_ready  out  1  holding register accepts a load
cmd  out  8  first 8 bits received in the last complete frame
cmd_valid  out  1  one-cycle pulse, cmd updated
frame_done  out  1  one-cycle pulse, frame ended after >= LEAD_BITS+DATA_BITS falling edges
frame_abort  out  1  one-cycle pulse, frame ended early
stale  out  1  current/last frame sent a sample already sent before
busy  out  1  frame in progress (ACTIVE state)

Behaviour:
- Reset values: all outputs 0; holding register 0; fresh flag 0; synchronizer sce stages 1, sck/sout stages 0; FSM in WAIT_IDLE.
- Sync/edge detection:
  - Inputs pass through SYNC_STAGES flops plus one history flop.
  - Edges are detected on synchronized values.
  - Response latency from a pin edge to its effect is SYNC_STAGES+1 clk.
  - Master sck half-period must be >= SYNC_STAGES+2 clk.
- Holding register:
  - sample_ready=1 whenever not in reset.
  - On sample_valid, load sample_data and set fresh=1.
- FSM:
  - WAIT_IDLE: wait for synchronized sce=1, then go to IDLE. This prevents joining a frame that was in progress when rst was released.
  - IDLE: on sce falling edge, go to ACTIVE.
    - Copy the holding register into the shift register, zero-extended with LEAD_BITS leading zeros.
    - stale <= ~fresh; fresh <= 0.
    - If sample_valid is high in the same cycle, the new word is stored with fresh=1. It does not enter this frame.
    - bit_cnt=0; drive adc_sin = first frame bit.
  - ACTIVE:
    - sck rising edge: shift adc_sout into rx register; rx_cnt saturates at 8.
    - sck falling edge: bit_cnt++, saturating at LEAD_BITS+DATA_BITS. adc_sin = next frame bit, or 0 once all bits are sent.
    - sce rising edge: go to IDLE, busy=0, adc_sin=0.
      - frame_done pulse if bit_cnt >= LEAD_BITS+DATA_BITS, else frame_abort pulse.
      - If rx_cnt == 8: cmd <= rx, cmd_valid pulse.
    - sce rise wins over a coincident sck edge, which is ignored.
- Extra clocks beyond the frame length shift out 0 and do not wrap.
- Holding-register loads during ACTIVE never alter the shift register.
- adc_sin is 0 whenever not ACTIVE. busy=1 exactly while ACTIVE.
- rst asserted mid-frame: immediate return to reset values and WAIT_IDLE. No frame_done/abort pulse.
- stale holds its value until the next frame start.

Test Plan:
- Load 0xA5C; CE low; 15 sck cycles; CE high. Required response:
  - Master reads 000 then 101001011100.
  - frame_done pulses once; stale=0; busy high throughout.
- Second frame with no new load: same bits returned; stale=1.
- Mid-frame, load 0x123 while shifting 0xA5C: current frame still yields 0xA5C. Next frame yields 0x123 with stale=0.
- Master sends 0xC3 during first 8 clocks of a 15-clock frame: cmd=0xC3 and cmd_valid pulses once at CE rise.
- CE raised after 6 clocks: frame_abort pulses; no frame_done; no cmd_valid. The next full frame is correct.
- Assert rst for 1 cycle mid-frame with CE held low: adc_sin=0, no pulses, no response until CE returns high. The next frame is correct and returns holding value 0 with stale=1.
